minigame_sched: RTL and testbench

Session controller for the LED reaction minigame. It launches the game on a start-button edge and times each session in 0.1 s ticks. It ends a session on game completion, watchdog timeout or user abort, force-resetting the game on timeout or abort. It keeps win/loss counters and the best completion time, and arbitrates the board LEDs between the clock display path and the game. It sits between the top-level mode logic and the minigame instance.

---
 rtl/minigame_sched.sv | 173 +++++++++++++++++
 tb/tb_minigame_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/minigame_sched.sv
// Session controller for the LED reaction minigame: launch on start edge, time in ticks,
// end on done/abort/timeout, keep win/loss stats and best time, arbitrate board LEDs.
module minigame_sched #(
   parameter int TICK_CYCLES     = 5_000_000,
   parameter int TIMEOUT_TICKS   = 200,
   parameter int COOLDOWN_CYCLES = 50_000_000
) (
   input  logic        MCLK,
   input  logic        RESET_N,
   input  logic        start_btn,
   input  logic        abort_btn,
   input  logic        game_done,
   input  logic [3:0]  game_score,
   input  logic [9:0]  game_led,
   input  logic [9:0]  clock_led,
   output logic        game_enable,
   output logic        game_rst,
   output logic [9:0]  led_out,
   output logic        busy,
   output logic [7:0]  win_count,
   output logic [7:0]  loss_count,
   output logic [3:0]  last_score,
   output logic [15:0] last_time,
   output logic [15:0] best_time
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LAUNCH   = 3'd1;
   localparam logic [2:0] S_RUN      = 3'd2;
   localparam logic [2:0] S_ABORT    = 3'd3;
   localparam logic [2:0] S_RESULT   = 3'd4;
   localparam logic [2:0] S_COOLDOWN = 3'd5;

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
   localparam logic [15:0]   TIMEOUT   = 16'(TIMEOUT_TICKS);

   logic [2:0]    state_q, state_d;
   logic          start_prev_q;
   logic [TW-1:0] tick_q, tick_d;
   logic [15:0]   elapsed_q, elapsed_d;
   logic [CW-1:0] cool_q, cool_d;
   logic          abort_cnt_q, abort_cnt_d;
   logic          win_q, win_d;
   logic [3:0]    score_q, score_d;
   logic          game_enable_q, game_enable_d;
   logic          game_rst_q, game_rst_d;
   logic [7:0]    win_count_q, win_count_d;
   logic [7:0]    loss_count_q, loss_count_d;
   logic [3:0]    last_score_q, last_score_d;
   logic [15:0]   last_time_q, last_time_d;
   logic [15:0]   best_time_q, best_time_d;
   logic          start_edge;

   assign start_edge = start_btn & ~start_prev_q;

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      elapsed_d    = elapsed_q;
      cool_d       = cool_q;
      abort_cnt_d  = abort_cnt_q;
      win_d        = win_q;
      score_d      = score_q;
      win_count_d  = win_count_q;
      loss_count_d = loss_count_q;
      last_score_d = last_score_q;
      last_time_d  = last_time_q;
      best_time_d  = best_time_q;
      case (state_q)
         S_IDLE: begin
            tick_d    = '0;
            elapsed_d = '0;
            if (start_edge) state_d = S_LAUNCH;
         end
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (elapsed_q != 16'hFFFF) elapsed_d = elapsed_q + 16'd1;
            end else begin
               tick_d = tick_q + TW'(1);
            end
            // done outranks abort, which outranks timeout
            if (game_done) begin
               state_d = S_RESULT;
               win_d   = 1'b1;
               score_d = game_score;
            end else if (abort_btn || (elapsed_q == TIMEOUT)) begin
               state_d     = S_ABORT;
               win_d       = 1'b0;
               score_d     = game_score;
               abort_cnt_d = 1'b0;
            end
         end
         S_ABORT: begin
            abort_cnt_d = 1'b1;
            if (abort_cnt_q) state_d = S_RESULT;
         end
         S_RESULT: begin
            last_time_d  = elapsed_q;
            last_score_d = score_q;
            if (win_q) begin
               if (win_count_q != 8'hFF) win_count_d = win_count_q + 8'd1;
               if (elapsed_q < best_time_q) best_time_d = elapsed_q;
            end else if (loss_count_q != 8'hFF) begin
               loss_count_d = loss_count_q + 8'd1;
            end
            cool_d  = '0;
            state_d = S_COOLDOWN;
         end
         S_COOLDOWN: begin
            if (cool_q == COOL_LAST) state_d = S_IDLE;
            else cool_d = cool_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Enable drops immediately on an abort exit but one cycle after a win exit.
   assign game_enable_d = (state_q == S_LAUNCH) || ((state_q == S_RUN) && (state_d != S_ABORT));
   assign game_rst_d    = (state_d == S_ABORT);

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= S_IDLE;
         start_prev_q  <= 1'b0;
         tick_q        <= '0;
         elapsed_q     <= '0;
         cool_q        <= '0;
         abort_cnt_q   <= 1'b0;
         win_q         <= 1'b0;
         score_q       <= '0;
         game_enable_q <= 1'b0;
         game_rst_q    <= 1'b1;
         win_count_q   <= '0;
         loss_count_q  <= '0;
         last_score_q  <= '0;
         last_time_q   <= '0;
         best_time_q   <= 16'hFFFF;
      end else begin
         state_q       <= state_d;
         start_prev_q  <= start_btn;
         tick_q        <= tick_d;
         elapsed_q     <= elapsed_d;
         cool_q        <= cool_d;
         abort_cnt_q   <= abort_cnt_d;
         win_q         <= win_d;
         score_q       <= score_d;
         game_enable_q <= game_enable_d;
         game_rst_q    <= game_rst_d;
         win_count_q   <= win_count_d;
         loss_count_q  <= loss_count_d;
         last_score_q  <= last_score_d;
         last_time_q   <= last_time_d;
         best_time_q   <= best_time_d;
      end
   end

   assign game_enable = game_enable_q;
   assign game_rst    = game_rst_q;
   assign busy        = (state_q != S_IDLE);
   assign led_out     = ((state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_ABORT))
                        ? game_led : clock_led;
   assign win_count   = win_count_q;
   assign loss_count  = loss_count_q;
   assign last_score  = last_score_q;
   assign last_time   = last_time_q;
   assign best_time   = best_time_q;

endmodule

// File: tb/tb_minigame_sched.sv
// Directed bench for minigame_sched with TICK_CYCLES=4, TIMEOUT_TICKS=10, COOLDOWN_CYCLES=8.
module tb_minigame_sched;

   logic        MCLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        start_btn = 1'b0;
   logic        abort_btn = 1'b0;
   logic        game_done = 1'b0;
   logic [3:0]  game_score = 4'd0;
   logic [9:0]  game_led = 10'h2AA;
   logic [9:0]  clock_led = 10'h155;
   logic        game_enable, game_rst, busy;
   logic [9:0]  led_out;
   logic [7:0]  win_count, loss_count;
   logic [3:0]  last_score;
   logic [15:0] last_time, best_time;

   int total = 0;
   int bad = 0;
   int rises = 0;
   int rst_cnt = 0;

   minigame_sched #(.TICK_CYCLES(4), .TIMEOUT_TICKS(10), .COOLDOWN_CYCLES(8)) dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .start_btn(start_btn), .abort_btn(abort_btn),
      .game_done(game_done), .game_score(game_score), .game_led(game_led),
      .clock_led(clock_led), .game_enable(game_enable), .game_rst(game_rst),
      .led_out(led_out), .busy(busy), .win_count(win_count), .loss_count(loss_count),
      .last_score(last_score), .last_time(last_time), .best_time(best_time)
   );

   always #5 MCLK = ~MCLK;

   always @(posedge game_enable) rises++;
   always @(negedge MCLK) if (game_rst === 1'b1) rst_cnt++;

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   // Returns to S_IDLE within a bounded number of cycles.
   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_idle_timeout busy=%b want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if (game_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", game_enable); end
      total++; if (game_rst !== 1'b1) begin bad++; $display("FAIL rst_game_rst got=%b want=1", game_rst); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (best_time !== 16'hFFFF) begin bad++; $display("FAIL rst_best got=%h want=ffff", best_time); end
      total++; if (win_count !== 8'd0 || loss_count !== 8'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", win_count, loss_count); end
      total++; if (led_out !== 10'h155) begin bad++; $display("FAIL rst_led got=%h want=155", led_out); end
      RESET_N = 1'b1;
      tick();
      total++; if (game_rst !== 1'b0) begin bad++; $display("FAIL rst_release got=%b want=0", game_rst); end
   endtask

   task automatic test_win();
      int r0 = rises;
      game_score = 4'd3;
      start_btn = 1'b1;
      tick();
      total++; if (busy !== 1'b1 || game_enable !== 1'b0 || led_out !== 10'h2AA) begin bad++; $display("FAIL win_launch busy=%b en=%b led=%h want 1/0/2aa", busy, game_enable, led_out); end
      start_btn = 1'b0;
      tick();
      total++; if (game_enable !== 1'b1) begin bad++; $display("FAIL win_enable got=%b want=1", game_enable); end
      repeat (22) tick();
      game_done = 1'b1;
      tick();
      game_done = 1'b0;
      total++; if (led_out !== 10'h155) begin bad++; $display("FAIL win_result_led got=%h want=155", led_out); end
      tick();
      total++; if (win_count !== 8'd1) begin bad++; $display("FAIL win_count got=%0d want=1", win_count); end
      total++; if (last_time !== 16'd5) begin bad++; $display("FAIL win_last_time got=%0d want=5", last_time); end
      total++; if (best_time !== 16'd5) begin bad++; $display("FAIL win_best got=%0d want=5", best_time); end
      total++; if (last_score !== 4'd3) begin bad++; $display("FAIL win_score got=%0d want=3", last_score); end
      total++; if (loss_count !== 8'd0) begin bad++; $display("FAIL win_loss got=%0d want=0", loss_count); end
      total++; if (game_enable !== 1'b0) begin bad++; $display("FAIL win_enable_low got=%b want=0", game_enable); end
      total++; if (rises - r0 !== 1) begin bad++; $display("FAIL win_rises got=%0d want=1", rises - r0); end
      repeat (7) tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL win_cool_busy got=%b want=1", busy); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL win_cool_end got=%b want=0", busy); end
   endtask

   task automatic test_timeout();
      int n = 0;
      int rc0 = rst_cnt;
      game_score = 4'd1;
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick();
      while (game_rst !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total++; if (n != 41) begin bad++; $display("FAIL to_detect_cycle got=%0d want=41", n); end
      total++; if (game_enable !== 1'b0 || led_out !== 10'h2AA) begin bad++; $display("FAIL to_abort en=%b led=%h want 0/2aa", game_enable, led_out); end
      tick();
      total++; if (game_rst !== 1'b1) begin bad++; $display("FAIL to_rst2 got=%b want=1", game_rst); end
      tick();
      total++; if (game_rst !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL to_result rst=%b busy=%b want 0/1", game_rst, busy); end
      tick();
      total++; if (loss_count !== 8'd1) begin bad++; $display("FAIL to_loss got=%0d want=1", loss_count); end
      total++; if (last_time !== 16'd10) begin bad++; $display("FAIL to_last_time got=%0d want=10", last_time); end
      total++; if (best_time !== 16'd5 || win_count !== 8'd1) begin bad++; $display("FAIL to_best best=%0d win=%0d want 5/1", best_time, win_count); end
      total++; if (last_score !== 4'd1) begin bad++; $display("FAIL to_score got=%0d want=1", last_score); end
      wait_idle("to");
      total++; if (rst_cnt - rc0 !== 2) begin bad++; $display("FAIL to_rst_cycles got=%0d want=2", rst_cnt - rc0); end
   endtask

   task automatic test_abort_done();
      int rc0 = rst_cnt;
      game_score = 4'd2;
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick();
      repeat (6) tick();
      abort_btn = 1'b1;
      game_done = 1'b1;
      tick();
      abort_btn = 1'b0;
      game_done = 1'b0;
      tick();
      total++; if (win_count !== 8'd2 || loss_count !== 8'd1) begin bad++; $display("FAIL ad_counts got=%0d/%0d want=2/1", win_count, loss_count); end
      total++; if (last_time !== 16'd1 || last_score !== 4'd2) begin bad++; $display("FAIL ad_stats time=%0d score=%0d want 1/2", last_time, last_score); end
      wait_idle("ad");
      total++; if (rst_cnt - rc0 !== 0) begin bad++; $display("FAIL ad_rst got=%0d want=0", rst_cnt - rc0); end
   endtask

   task automatic test_cooldown_edges();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick();
      repeat (2) tick();
      game_done = 1'b1;
      tick();
      game_done = 1'b0;
      tick();
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick();
      start_btn = 1'b1;
      wait_idle("cd");
      repeat (3) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cd_held_start busy=%b want=0", busy); end
      total++; if (win_count !== 8'd3) begin bad++; $display("FAIL cd_wins got=%0d want=3", win_count); end
      start_btn = 1'b0;
      tick();
      start_btn = 1'b1;
      tick();
      total++; if (busy !== 1'b1 || led_out !== 10'h2AA) begin bad++; $display("FAIL cd_repress busy=%b led=%h want 1/2aa", busy, led_out); end
      start_btn = 1'b0;
      tick();
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_run();
      total++; if (busy !== 1'b1 || game_enable !== 1'b1) begin bad++; $display("FAIL mr_running busy=%b en=%b want 1/1", busy, game_enable); end
      RESET_N = 1'b0;
      #1;
      total++; if (game_rst !== 1'b1 || game_enable !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_ctrl rst=%b en=%b busy=%b want 1/0/0", game_rst, game_enable, busy); end
      total++; if (win_count !== 8'd0 || loss_count !== 8'd0 || last_score !== 4'd0 || last_time !== 16'd0) begin bad++; $display("FAIL mr_stats w=%0d l=%0d s=%0d t=%0d want 0", win_count, loss_count, last_score, last_time); end
      total++; if (best_time !== 16'hFFFF || led_out !== 10'h155) begin bad++; $display("FAIL mr_best best=%h led=%h want ffff/155", best_time, led_out); end
      tick();
      RESET_N = 1'b1;
      #1;
      total++; if (game_rst !== 1'b1) begin bad++; $display("FAIL mr_hold got=%b want=1", game_rst); end
      tick();
      total++; if (game_rst !== 1'b0) begin bad++; $display("FAIL mr_release got=%b want=0", game_rst); end
   endtask

   task automatic test_best_led();
      int ticks[3] = '{7, 4, 9};
      logic [15:0] exp_best[3] = '{16'd7, 16'd4, 16'd4};
      game_done = 1'b1;
      tick();
      game_done = 1'b0;
      tick();
      total++; if (win_count !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL bl_idle_done w=%0d busy=%b want 0/0", win_count, busy); end
      clock_led = 10'h0F0;
      #1;
      total++; if (led_out !== 10'h0F0) begin bad++; $display("FAIL bl_idle_led got=%h want=0f0", led_out); end
      for (int i = 0; i < 3; i++) begin
         start_btn = 1'b1;
         tick();
         start_btn = 1'b0;
         tick();
         game_led = 10'h300 + 10'(i);
         #1;
         total++; if (led_out !== 10'h300 + 10'(i)) begin bad++; $display("FAIL bl_run_led%0d got=%h want=%h", i, led_out, 10'h300 + 10'(i)); end
         repeat (4 * ticks[i] + 1) tick();
         game_done = 1'b1;
         tick();
         game_done = 1'b0;
         tick();
         total++; if (best_time !== exp_best[i] || last_time !== 16'(ticks[i])) begin bad++; $display("FAIL bl_best%0d best=%0d last=%0d want %0d/%0d", i, best_time, last_time, exp_best[i], ticks[i]); end
         total++; if (led_out !== 10'h0F0) begin bad++; $display("FAIL bl_cool_led%0d got=%h want=0f0", i, led_out); end
         wait_idle("bl");
      end
      total++; if (win_count !== 8'd3) begin bad++; $display("FAIL bl_wins got=%0d want=3", win_count); end
   endtask

   initial begin
      test_reset();
      test_win();
      test_timeout();
      test_abort_done();
      test_cooldown_edges();
      test_reset_mid_run();
      test_best_led();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
